// File: rtl/carregador_serial_16b.sv
// Serial-to-parallel loader feeding registrador_16b.
// Assembles a WIDTH-bit word from a bit-serial stream, optionally checks an
// even-parity trailer bit, and drives a one-cycle load strobe with the word.
module carregador_serial_16b #(
  parameter int WIDTH     = 16,
  parameter int PARITY_EN = 1,
  parameter int MSB_FIRST = 1,
  localparam int CW       = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             busy,
  output logic             l_out,
  output logic [WIDTH-1:0] d_out,
  output logic             parity_err,
  output logic [CW-1:0]    count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sr_q, sr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [WIDTH-1:0]   d_out_q, d_out_d;
  logic               l_out_q, l_out_d;
  logic               parity_err_q, parity_err_d;

  logic [WIDTH-1:0]   sr_shifted;
  logic               last_data_bit;
  logic               parity_ok;

  // Shift register with the incoming bit inserted at the configured end.
  always_comb begin
    sr_shifted = sr_q;
    if (MSB_FIRST != 0) begin
      sr_shifted = {sr_q[WIDTH-2:0], bit_in};
    end else begin
      sr_shifted = {bit_in, sr_q[WIDTH-1:1]};
    end
  end

  assign last_data_bit = (count_q == CW'(WIDTH - 1));
  assign parity_ok     = (bit_in == ^sr_q);

  // Next-state and next-output computation for the frame FSM.
  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    count_d      = count_q;
    d_out_d      = d_out_q;
    l_out_d      = 1'b0;
    parity_err_d = parity_err_q;

    unique case (state_q)
      ST_IDLE: begin
        // A bit_valid coinciding with start is deliberately not captured.
        if (start) begin
          state_d      = ST_SHIFT;
          sr_d         = '0;
          count_d      = '0;
          parity_err_d = 1'b0;
        end
      end

      ST_SHIFT: begin
        if (bit_valid) begin
          sr_d = sr_shifted;
          if (count_q != CW'(WIDTH)) begin
            count_d = count_q + CW'(1);
          end
          if (last_data_bit) begin
            if (PARITY_EN != 0) begin
              state_d = ST_PARITY;
            end else begin
              // Word includes the bit shifted in on this same edge.
              state_d = ST_IDLE;
              d_out_d = sr_shifted;
              l_out_d = 1'b1;
            end
          end
        end
      end

      ST_PARITY: begin
        if (bit_valid) begin
          state_d = ST_IDLE;
          if (parity_ok) begin
            d_out_d = sr_q;
            l_out_d = 1'b1;
          end else begin
            parity_err_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sr_q         <= '0;
      count_q      <= '0;
      d_out_q      <= '0;
      l_out_q      <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      count_q      <= count_d;
      d_out_q      <= d_out_d;
      l_out_q      <= l_out_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign l_out      = l_out_q;
  assign d_out      = d_out_q;
  assign parity_err = parity_err_q;
  assign count      = count_q;

endmodule

// File: tb/tb_carregador_serial_16b.sv
// Self-checking bench for carregador_serial_16b: three builds (MSB-first with
// parity, LSB-first with parity, MSB-first without parity) share one stimulus
// stream and are compared every cycle against a frame-level reference model,
// plus table-driven and hand-written directed frames on the default build.
module tb_carregador_serial_16b;

  logic clk = 1'b0;
  logic rst, start, bit_valid, bit_in;

  logic        busy_w  [3];
  logic        l_w     [3];
  logic [15:0] d_w     [3];
  logic        err_w   [3];
  logic [4:0]  count_w [3];

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  always #5 clk = ~clk;

  carregador_serial_16b #(.WIDTH(16), .PARITY_EN(1), .MSB_FIRST(1)) u0 (
    .clk(clk), .rst(rst), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
    .busy(busy_w[0]), .l_out(l_w[0]), .d_out(d_w[0]), .parity_err(err_w[0]),
    .count(count_w[0]));

  carregador_serial_16b #(.WIDTH(16), .PARITY_EN(1), .MSB_FIRST(0)) u1 (
    .clk(clk), .rst(rst), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
    .busy(busy_w[1]), .l_out(l_w[1]), .d_out(d_w[1]), .parity_err(err_w[1]),
    .count(count_w[1]));

  carregador_serial_16b #(.WIDTH(16), .PARITY_EN(0), .MSB_FIRST(1)) u2 (
    .clk(clk), .rst(rst), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
    .busy(busy_w[2]), .l_out(l_w[2]), .d_out(d_w[2]), .parity_err(err_w[2]),
    .count(count_w[2]));

  // Downstream registrador_16b stand-in fed by the default build.
  logic [15:0] regq;
  always_ff @(posedge clk) begin
    if (rst) regq <= '0;
    else if (l_w[0]) regq <= d_w[0];
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic int pe(input int k);
    return (k == 2) ? 0 : 1;
  endfunction

  function automatic int msbf(input int k);
    return (k == 1) ? 0 : 1;
  endfunction

  // Reference model: collect the frame's bits, judge the frame once complete.
  bit          act [3];
  int          nb  [3];
  logic [16:0] fb  [3];
  logic [15:0] md  [3];
  logic        ml  [3];
  logic        me  [3];
  int          mc  [3];

  always begin
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        act[k] = 1'b0; nb[k] = 0; fb[k] = '0; md[k] = '0;
        ml[k] = 1'b0; me[k] = 1'b0; mc[k] = 0;
      end else begin
        ml[k] = 1'b0;
        if (!act[k]) begin
          if (start) begin
            act[k] = 1'b1; nb[k] = 0; fb[k] = '0; mc[k] = 0; me[k] = 1'b0;
          end
        end else if (bit_valid) begin
          fb[k][nb[k]] = bit_in;
          nb[k]++;
          mc[k] = (nb[k] > 16) ? 16 : nb[k];
          if (nb[k] == 16 + pe(k)) begin
            logic [15:0] w;
            for (int j = 0; j < 16; j++) begin
              if (msbf(k) != 0) w[15-j] = fb[k][j];
              else              w[j]    = fb[k][j];
            end
            if (pe(k) == 0 || ($countones(fb[k]) % 2) == 0) begin
              md[k] = w;
              ml[k] = 1'b1;
            end else begin
              me[k] = 1'b1;
            end
            act[k] = 1'b0;
          end
        end
      end
    end
    #2;
    if (mon_en) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("mon%0d_busy", k),  32'(busy_w[k]),  32'(act[k]));
        chk($sformatf("mon%0d_l", k),     32'(l_w[k]),     32'(ml[k]));
        chk($sformatf("mon%0d_d", k),     32'(d_w[k]),     32'(md[k]));
        chk($sformatf("mon%0d_err", k),   32'(err_w[k]),   32'(me[k]));
        chk($sformatf("mon%0d_count", k), 32'(count_w[k]), 32'(mc[k]));
      end
    end
  end

  // One clock cycle with the given inputs; returns 1 time unit after the edge.
  task automatic cyc(input logic s, input logic v, input logic b);
    start = s; bit_valid = v; bit_in = b;
    @(posedge clk);
    #1;
  endtask

  // Start pulse, 16 MSB-first data bits with gap idle cycles after each, then parity.
  task automatic send_frame(input logic [15:0] w, input logic par, input int gap);
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1, w[15-i]);
      chk("frame_count", 32'(count_w[0]), 32'(i + 1));
      for (int g = 0; g < gap; g++) begin
        cyc(1'b0, 1'b0, 1'b1);
        chk("gap_count", 32'(count_w[0]), 32'(i + 1));
      end
    end
    cyc(1'b0, 1'b1, par);
  endtask

  typedef struct {
    logic [15:0] word;
    logic        par;
    int          gap;
    logic        exp_l;
    logic [15:0] exp_d;
    logic        exp_err;
  } vec_t;

  vec_t vec [7];

  initial begin
    logic [15:0] tw;
    logic        tp;

    vec[0] = '{16'hA5C3, 1'b0, 0, 1'b1, 16'hA5C3, 1'b0};
    vec[1] = '{16'hA5C3, 1'b1, 0, 1'b0, 16'hA5C3, 1'b1};
    vec[2] = '{16'h00FF, 1'b0, 3, 1'b1, 16'h00FF, 1'b0};
    vec[3] = '{16'h0001, 1'b1, 0, 1'b1, 16'h0001, 1'b0};
    vec[4] = '{16'h8000, 1'b1, 1, 1'b1, 16'h8000, 1'b0};
    vec[5] = '{16'hFFFF, 1'b1, 0, 1'b0, 16'h8000, 1'b1};
    vec[6] = '{16'hFFFF, 1'b0, 0, 1'b1, 16'hFFFF, 1'b0};

    // Reset with random inputs.
    rst = 1'b1;
    start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc(1'($urandom), 1'($urandom), 1'($urandom));
    end
    mon_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_busy",  32'(busy_w[k]),  32'd0);
      chk("rst_l",     32'(l_w[k]),     32'd0);
      chk("rst_d",     32'(d_w[k]),     32'h0000);
      chk("rst_err",   32'(err_w[k]),   32'd0);
      chk("rst_count", 32'(count_w[k]), 32'd0);
    end
    rst = 1'b0;

    // Table-driven frames on the default build.
    for (int t = 0; t < 7; t++) begin
      send_frame(vec[t].word, vec[t].par, vec[t].gap);
      chk("tbl_l",    32'(l_w[0]),    32'(vec[t].exp_l));
      chk("tbl_d",    32'(d_w[0]),    32'(vec[t].exp_d));
      chk("tbl_err",  32'(err_w[0]),  32'(vec[t].exp_err));
      chk("tbl_busy", 32'(busy_w[0]), 32'd0);
      cyc(1'b0, 1'b0, 1'b0);
      chk("tbl_l_one_cycle", 32'(l_w[0]), 32'd0);
      chk("tbl_d_hold",      32'(d_w[0]), 32'(vec[t].exp_d));
      if (vec[t].exp_l) chk("tbl_regq", 32'(regq), 32'(vec[t].exp_d));
    end

    // Reset after 7 bits discards the partial word.
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 1'b1);
    chk("mid_count", 32'(count_w[0]), 32'd7);
    chk("mid_busy",  32'(busy_w[0]),  32'd1);
    rst = 1'b1;
    cyc(1'b0, 1'b1, 1'b1);
    rst = 1'b0;
    chk("mid_rst_busy",  32'(busy_w[0]),  32'd0);
    chk("mid_rst_count", 32'(count_w[0]), 32'd0);
    chk("mid_rst_d",     32'(d_w[0]),     32'h0000);
    chk("mid_rst_l",     32'(l_w[0]),     32'd0);
    send_frame(16'h0001, 1'b1, 0);
    chk("after_rst_l", 32'(l_w[0]), 32'd1);
    chk("after_rst_d", 32'(d_w[0]), 32'h0001);
    cyc(1'b0, 1'b0, 1'b0);

    // start with bit_valid in IDLE, and start re-pulsed mid-frame.
    cyc(1'b1, 1'b1, 1'b1);
    chk("sv_busy",  32'(busy_w[0]),  32'd1);
    chk("sv_count", 32'(count_w[0]), 32'd0);
    for (int i = 0; i < 16; i++) begin
      cyc((i == 5) ? 1'b1 : 1'b0, 1'b1, (i == 0) ? 1'b1 : 1'b0);
    end
    cyc(1'b0, 1'b1, 1'b1);
    chk("lsb_l",   32'(l_w[1]),   32'd1);
    chk("lsb_d",   32'(d_w[1]),   32'h0001);
    chk("lsb_err", 32'(err_w[1]), 32'd0);
    chk("msb_d",   32'(d_w[0]),   32'h8000);
    chk("nopar_d", 32'(d_w[2]),   32'h8000);
    chk("nopar_l", 32'(l_w[2]),   32'd0);
    cyc(1'b0, 1'b0, 1'b0);

    // Back-to-back frames: next start lands in the l_out cycle.
    tw = 16'h1234;
    tp = ^tw;
    send_frame(tw, tp, 0);
    chk("b2b_l1", 32'(l_w[0]), 32'd1);
    chk("b2b_d1", 32'(d_w[0]), 32'h1234);
    send_frame(16'h0F0F, 1'b0, 0);
    chk("b2b_l2", 32'(l_w[0]), 32'd1);
    chk("b2b_d2", 32'(d_w[0]), 32'h0F0F);
    cyc(1'b0, 1'b0, 1'b0);

    // Random cycle-level stimulus, checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      cyc(($urandom_range(0, 7) == 0), ($urandom_range(0, 2) != 0), 1'($urandom));
    end
    rst = 1'b0;
    repeat (4) cyc(1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
